// File: rtl/sodor_mem_pkg.sv
// Shared constants and payload types for the Sodor memory request/response interface.
package sodor_mem_pkg;

    localparam int unsigned XLEN = 32;

    // Access types carried on req_typ
    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    // Request function carried on req_fcn
    localparam logic FCN_R = 1'b0;
    localparam logic FCN_W = 1'b1;

    // One response pipeline stage
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] data;
    } resp_t;

endpackage

// File: rtl/sodor_mem_lane_fmt.sv
// Per-port lane formatter: byte enables / replicated write data, and read extraction with extension.
module sodor_mem_lane_fmt
    import sodor_mem_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      typ,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Decode lane selection from the low address bits and access type; unknown types act as word
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        rbyte   = rword[{addr_lo, 3'b000} +: 8];
        rhalf   = rword[{addr_lo[1], 4'b0000} +: 16];
        rdata_c = rword;
        case (typ)
            MT_B, MT_BU: begin
                be_c    = 4'(4'b0001 << addr_lo);
                wdata_c = {4{wdata[7:0]}};
                rdata_c = (typ == MT_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
            end
            MT_H, MT_HU: begin
                be_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
                rdata_c = (typ == MT_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
                rdata_c = rword;
            end
        endcase
    end

endmodule

// File: rtl/sodor_mem_responder.sv
// Dual-port fixed-latency memory responder for the Sodor core and debug ports.
module sodor_mem_responder
    import sodor_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        p0_req_valid,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_data,
    input  logic        p0_req_fcn,
    input  logic [2:0]  p0_req_typ,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_data,

    input  logic        p1_req_valid,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_data,
    input  logic        p1_req_fcn,
    input  logic [2:0]  p1_req_typ,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_data,

    output logic        err_sticky
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned HI_L = AW + 2;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [AW-1:0]   idx0, idx1;
    logic            oor0, oor1;
    logic            we0, we1;
    logic [XLEN-1:0] rword0, rword1;
    logic [3:0]      be0, be1, be0_eff;
    logic [XLEN-1:0] wd0, wd1, rd0, rd1;

    resp_t           p0_pipe_q [LATENCY];
    resp_t           p0_pipe_d [LATENCY];
    resp_t           p1_pipe_q [LATENCY];
    resp_t           p1_pipe_d [LATENCY];
    logic            err_q, err_d;

    // Address decode, range check and read-before-write array lookup
    always_comb begin
        idx0    = p0_req_addr[AW+1:2];
        idx1    = p1_req_addr[AW+1:2];
        oor0    = (p0_req_addr >> HI_L) != 32'd0;
        oor1    = (p1_req_addr >> HI_L) != 32'd0;
        we0     = p0_req_valid && (p0_req_fcn == FCN_W) && !oor0;
        we1     = p1_req_valid && (p1_req_fcn == FCN_W) && !oor1;
        rword0  = mem_q[idx0];
        rword1  = mem_q[idx1];
        // Debug port owns any lane both ports write in the same word
        be0_eff = (we1 && (idx0 == idx1)) ? (be0 & ~be1) : be0;
    end

    sodor_mem_lane_fmt u_fmt0 (
        .addr_lo (p0_req_addr[1:0]),
        .typ     (p0_req_typ),
        .wdata   (p0_req_data),
        .rword   (rword0),
        .be_c    (be0),
        .wdata_c (wd0),
        .rdata_c (rd0)
    );

    sodor_mem_lane_fmt u_fmt1 (
        .addr_lo (p1_req_addr[1:0]),
        .typ     (p1_req_typ),
        .wdata   (p1_req_data),
        .rword   (rword1),
        .be_c    (be1),
        .wdata_c (wd1),
        .rdata_c (rd1)
    );

    // Byte-lane write commit; array contents survive reset
    always_ff @(posedge clock) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we0 && be0_eff[b]) mem_q[idx0][8*b +: 8] <= wd0[8*b +: 8];
            if (we1 && be1[b])     mem_q[idx1][8*b +: 8] <= wd1[8*b +: 8];
        end
    end

    // Response shift pipelines and sticky error next-state
    always_comb begin
        p0_pipe_d[0].valid = p0_req_valid;
        p0_pipe_d[0].data  = ((p0_req_fcn == FCN_W) || oor0) ? 32'd0 : rd0;
        p1_pipe_d[0].valid = p1_req_valid;
        p1_pipe_d[0].data  = ((p1_req_fcn == FCN_W) || oor1) ? 32'd0 : rd1;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            p0_pipe_d[i] = p0_pipe_q[i-1];
            p1_pipe_d[i] = p1_pipe_q[i-1];
        end
        err_d = err_q || (p0_req_valid && oor0) || (p1_req_valid && oor1);
    end

    // Pipeline and error registers; reset drops in-flight responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                p0_pipe_q[i] <= '0;
                p1_pipe_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                p0_pipe_q[i] <= p0_pipe_d[i];
                p1_pipe_q[i] <= p1_pipe_d[i];
            end
            err_q <= err_d;
        end
    end

    assign p0_resp_valid = p0_pipe_q[LATENCY-1].valid;
    assign p0_resp_data  = p0_pipe_q[LATENCY-1].data;
    assign p1_resp_valid = p1_pipe_q[LATENCY-1].valid;
    assign p1_resp_data  = p1_pipe_q[LATENCY-1].data;
    assign err_sticky    = err_q;

endmodule

// File: doc/sodor_mem_responder.md
# sodor_mem_responder

Dual-port memory responder that terminates the Sodor core's memory request/response interface. It answers both the core master port (instruction/data traffic) and the debug port from one shared word array. Requests are accepted unconditionally every cycle; responses return after a fixed, parameterised latency. It sits opposite the core inside each copy of the self-composed product harness, so both copies see identical, deterministic memory timing.

## Interface
- DEPTH_WORDS, 1024: array size in 32-bit words; power of two.
- LATENCY, 1: request-to-response cycles, legal range 1..4.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- p0_req_valid  in  1  core port request strobe.
- p0_req_addr  in  32  byte address.
- p0_req_data  in  32  write data, byte lanes LSB-aligned.
- p0_req_fcn  in  1  0 = read, 1 = write.
- p0_req_typ  in  3  access type (MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6).
- p0_resp_valid  out  1  response strobe.
- p0_resp_data  out  32  read data, extended per typ.
- p1_*: same seven signals for the debug port.
- err_sticky  out  1  set on any out-of-range access; cleared only by reset.

## Operation
- Each port is independent; each cycle with req_valid high is one request. There is no backpressure, so no request is ever dropped for occupancy.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Address bits above that range must be zero; otherwise the access is out-of-range:
  - reads return 0;
  - writes are discarded;
  - err_sticky sets.
- Alignment rules:
  - byte: addr[1:0] selects the lane;
  - halfword: addr[1] selects the lane, addr[0] ignored;
  - word: addr[1:0] ignored.
- typ values 0, 4 and 7 are treated as MT_W.
- Writes update only the addressed byte lanes (byte-enable merge). They commit at the clock edge of the request cycle.
- Read data: MT_B and MT_H sign-extend; MT_BU and MT_HU zero-extend.
- Writes also produce a response (resp_valid high) with resp_data = 0.
- Same-cycle reads see pre-write contents (read-before-write), including for the port's own write and the other port's write.
- Same-cycle writes from both ports to the same word:
  - lanes written by both ports take p1 (debug wins);
  - disjoint lanes from both ports are merged.
- Array contents are not reset.

## Timing
- A request in cycle t produces resp_valid/resp_data in cycle t+LATENCY.
- Back-to-back requests produce back-to-back responses in order.
- Response path: the read result is registered at t+1, then passes through a LATENCY-1 stage valid/data shift pipeline per port.
- Reset values: p0/p1_resp_valid = 0, resp_data = 0, err_sticky = 0, all pipeline stages invalid.
- Reset asserted mid-operation: in-flight responses are discarded and never emitted. Writes already committed remain in the array.
- First request accepted: the first rising edge with reset_n high.

## Structure
- Shared package sodor_mem_pkg holds the constants MT_B/MT_H/MT_W/MT_BU/MT_HU and FCN_R/FCN_W. The product harness and bench also use this package.
- One sub-module, sodor_mem_lane_fmt, is instantiated once per port:
  - builds byte enables and write data from (addr[1:0], typ, data);
  - extracts and extends read data.
- The top level holds the array, the collision merge, the per-port response pipelines and err_sticky.

## Test plan
- LATENCY=1. p0 writes MT_W 0xDEADBEEF to 0x10, then reads MT_W 0x10 -> response in the cycle after each request; read data = 0xDEADBEEF.
- Write word 0x000080F0 to 0x20:
  - MT_B read 0x20 -> 0xFFFFFFF0;
  - MT_BU read 0x20 -> 0x000000F0;
  - MT_H read 0x20 -> 0xFFFF80F0;
  - MT_HU read 0x22 -> 0x00000000.
- Same cycle:
  - p0 MT_W writes 0x11111111 to 0x40, p1 MT_B writes 0xAA to 0x41 -> a later read of 0x40 returns 0x1111AA11;
  - a simultaneous p0 read of 0x40 returns the old value.
- LATENCY=3, p0 issues four consecutive reads -> four consecutive resp_valid cycles starting 3 cycles after the first request, in order.
- p1 read at 0x8000_0000 with DEPTH_WORDS=1024 -> resp_data = 0, err_sticky = 1 from the next cycle; a write to the same address leaves the array unchanged.
- LATENCY=3, reset_n pulsed low one cycle after a read -> resp_valid never asserts for that read; outputs are 0 during reset; previously written data persists.
